// File: rtl/ifetch_unit_pkg.sv
// Shared pipeline definitions for the instruction-fetch stage:
// NOP encoding, reset PC, fetch FSM state encoding and the 32-bit adder.
package ifetch_unit_pkg;

    // Bubble instruction handed to decode when no fetch is valid.
    localparam logic [31:0] NOP_INSN         = 32'h0000_0000;

    // PC loaded on reset.
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Fetch FSM states.
    localparam logic [1:0]  ST_IDLE = 2'd0;
    localparam logic [1:0]  ST_REQ  = 2'd1;
    localparam logic [1:0]  ST_HOLD = 2'd2;

    // Word alignment mask applied to redirect targets.
    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    // Shared 32-bit adder; wraps modulo 2^32.
    function automatic logic [31:0] add32(input logic [31:0] a, input logic [31:0] b);
        return a + b;
    endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// Instruction-memory req/ack bus between the fetch stage and instruction memory.
interface ifetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    // Fetch stage side: issues requests, receives data.
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    // Memory side: receives requests, returns data.
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/ifetch_unit_pc_next.sv
// Next-PC selection: accepted redirect, then pending redirect, then sequential +4.
module pc_next
    import ifetch_unit_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        redir_acc,
    input  logic [31:0] target,
    input  logic        pend_v,
    input  logic [31:0] pend_t,
    output logic [31:0] target_aligned,
    output logic [31:0] next_pc
);

    // Redirect targets are forced to word alignment.
    assign target_aligned = target & ALIGN_MASK;

    // Priority select of the next fetch address.
    always_comb begin
        next_pc = add32(pc, 32'd4);
        if (redir_acc) begin
            next_pc = target_aligned;
        end else if (pend_v) begin
            next_pc = pend_t;
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack bus, passes the
// word to decode combinationally, buffers it across a decode stall and applies
// redirects after one delay slot.
module ifetch_unit
    import ifetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP      = NOP_INSN
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          stall,
    input  logic          redirect,
    input  logic [31:0]   target,
    ifetch_unit_if.master imem,
    output logic [31:0]   instruction,
    output logic [31:0]   delay,
    output logic [31:0]   delay2,
    output logic          valid
);

    logic [1:0]  state_reg, state_next;
    logic [31:0] pc_reg;
    logic [31:0] fpc_reg;
    logic [31:0] buf_reg;
    logic        pend_v_reg;
    logic [31:0] pend_t_reg;

    logic        in_req;
    logic        in_hold;
    logic        fetch_done;
    logic        redir_acc;
    logic        pc_load;
    logic [31:0] next_pc;
    logic [31:0] target_aligned;

    assign in_req     = rstn && (state_reg == ST_REQ);
    assign in_hold    = rstn && (state_reg == ST_HOLD);
    assign fetch_done = in_req && imem.imem_ack;
    // A redirect under stall is dropped; decode repeats it once the stall clears.
    assign redir_acc  = rstn && redirect && !stall;
    // The PC moves on every fetch completion. In HOLD the PC already points past
    // the buffered delay slot, so a redirect accepted on hold exit loads it directly.
    assign pc_load    = fetch_done || (in_hold && redir_acc);

    pc_next u_pc_next (
        .pc             (pc_reg),
        .redir_acc      (redir_acc),
        .target         (target),
        .pend_v         (pend_v_reg),
        .pend_t         (pend_t_reg),
        .target_aligned (target_aligned),
        .next_pc        (next_pc)
    );

    // Fetch FSM transitions.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: state_next = ST_REQ;
            ST_REQ:  if (imem.imem_ack && stall) state_next = ST_HOLD;
            ST_HOLD: if (!stall) state_next = ST_REQ;
            default: state_next = ST_IDLE;
        endcase
    end

    // Bus and decode-side outputs; reset and IDLE present a bubble at RESET_PC.
    always_comb begin
        imem.imem_req  = 1'b0;
        imem.imem_addr = pc_reg;
        instruction    = NOP;
        valid          = 1'b0;
        delay          = add32(pc_reg, 32'd4);
        delay2         = add32(pc_reg, 32'd8);
        if (!rstn) begin
            imem.imem_addr = RESET_PC;
            delay          = add32(RESET_PC, 32'd4);
            delay2         = add32(RESET_PC, 32'd8);
        end else begin
            case (state_reg)
                ST_REQ: begin
                    imem.imem_req = 1'b1;
                    if (imem.imem_ack && !stall) begin
                        instruction = imem.imem_rdata;
                        valid       = 1'b1;
                    end
                end
                ST_HOLD: begin
                    instruction = buf_reg;
                    valid       = !stall;
                    delay       = add32(fpc_reg, 32'd4);
                    delay2      = add32(fpc_reg, 32'd8);
                end
                default: ;
            endcase
        end
    end

    // PC, stall buffer and pending-redirect state.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg  <= ST_IDLE;
            pc_reg     <= RESET_PC;
            fpc_reg    <= RESET_PC;
            buf_reg    <= NOP;
            pend_v_reg <= 1'b0;
            pend_t_reg <= RESET_PC;
        end else begin
            state_reg <= state_next;
            if (pc_load) begin
                pc_reg <= next_pc;
            end
            if (fetch_done && stall) begin
                buf_reg <= imem.imem_rdata;
                fpc_reg <= pc_reg;
            end
            // Any PC load consumes the pending redirect; otherwise remember the newest one.
            if (pc_load) begin
                pend_v_reg <= 1'b0;
            end else if (redir_acc) begin
                pend_v_reg <= 1'b1;
                pend_t_reg <= target_aligned;
            end
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Testbench for ifetch_unit: directed scenarios plus a randomized run checked
// against a delivered-instruction-stream reference model.
module tb_ifetch_unit;
    import ifetch_unit_pkg::*;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk      = 1'b0;
    logic        rstn     = 1'b0;
    logic        stall    = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] target   = 32'h0;
    logic        ack_en   = 1'b0;
    logic [31:0] instruction, delay, delay2;
    logic        valid;

    int total = 0;
    int bad   = 0;

    ifetch_unit_if imem();

    // Memory model: data is the address XOR a key, ack driven by the bench.
    assign imem.imem_ack   = ack_en;
    assign imem.imem_rdata = imem.imem_addr ^ KEY;

    ifetch_unit dut (
        .clk         (clk),
        .rstn        (rstn),
        .stall       (stall),
        .redirect    (redirect),
        .target      (target),
        .imem        (imem),
        .instruction (instruction),
        .delay       (delay),
        .delay2      (delay2),
        .valid       (valid)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0; ack_en = 1'b0; stall = 1'b0; redirect = 1'b0; target = 32'h0;
        repeat (2) step();
        rstn = 1'b1;
        step();
    endtask

    // Zero-wait fetch of n words starting from the current address.
    task automatic fetch_n(input int n);
        ack_en = 1'b1; stall = 1'b0; redirect = 1'b0;
        repeat (n) step();
    endtask

    task automatic test_reset();
        rstn = 1'b0; ack_en = 1'b1; stall = 1'b0; redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if ({imem.imem_req, valid, instruction, delay, delay2} !== {1'b0, 1'b0, NOP_INSN, 32'h4, 32'h8}) begin
                bad++;
                $display("FAIL reset_outputs: got req=%b valid=%b insn=%h delay=%h delay2=%h, want req=0 valid=0 insn=%h delay=4 delay2=8",
                         imem.imem_req, valid, instruction, delay, delay2, NOP_INSN);
            end
            step();
        end
        rstn = 1'b1;
        @(negedge clk);
        total++;
        if ({imem.imem_req, valid, instruction} !== {1'b0, 1'b0, NOP_INSN}) begin
            bad++;
            $display("FAIL reset_idle: got req=%b valid=%b insn=%h, want req=0 valid=0 insn=%h",
                     imem.imem_req, valid, instruction, NOP_INSN);
        end
        step();
        @(negedge clk);
        total++;
        if ({imem.imem_req, imem.imem_addr} !== {1'b1, 32'h0}) begin
            bad++;
            $display("FAIL reset_first_req: got req=%b addr=%h, want req=1 addr=00000000", imem.imem_req, imem.imem_addr);
        end
        $display("reset: first request addr=%h", imem.imem_addr);
        step();
    endtask

    task automatic test_zero_wait();
        logic [31:0] a;
        do_reset();
        ack_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = 32'(4 * i);
            @(negedge clk);
            total++;
            if ({imem.imem_addr, valid, instruction, delay, delay2} !== {a, 1'b1, a ^ KEY, a + 32'd4, a + 32'd8}) begin
                bad++;
                $display("FAIL zero_wait: got addr=%h valid=%b insn=%h delay=%h delay2=%h, want addr=%h valid=1 insn=%h delay=%h delay2=%h",
                         imem.imem_addr, valid, instruction, delay, delay2, a, a ^ KEY, a + 32'd4, a + 32'd8);
            end
            $display("zero_wait: pc=%h insn=%h", imem.imem_addr, instruction);
            step();
        end
    endtask

    task automatic test_wait_states();
        do_reset();
        fetch_n(2);
        ack_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++;
            if ({imem.imem_req, imem.imem_addr, valid, instruction} !== {1'b1, 32'h8, 1'b0, NOP_INSN}) begin
                bad++;
                $display("FAIL wait_bubble: got req=%b addr=%h valid=%b insn=%h, want req=1 addr=00000008 valid=0 insn=%h",
                         imem.imem_req, imem.imem_addr, valid, instruction, NOP_INSN);
            end
            step();
        end
        ack_en = 1'b1;
        @(negedge clk);
        total++;
        if ({imem.imem_addr, valid, instruction} !== {32'h8, 1'b1, 32'hA5A5_0008}) begin
            bad++;
            $display("FAIL wait_deliver: got addr=%h valid=%b insn=%h, want addr=00000008 valid=1 insn=a5a50008",
                     imem.imem_addr, valid, instruction);
        end
        $display("wait_states: pc=%h insn=%h", imem.imem_addr, instruction);
        step();
    endtask

    task automatic test_stall();
        do_reset();
        fetch_n(3);
        ack_en = 1'b1; stall = 1'b1;
        @(negedge clk);
        total++;
        if ({imem.imem_addr, valid} !== {32'hC, 1'b0}) begin
            bad++;
            $display("FAIL stall_ack: got addr=%h valid=%b, want addr=0000000c valid=0", imem.imem_addr, valid);
        end
        step();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++;
            if ({imem.imem_req, valid} !== 2'b00) begin
                bad++;
                $display("FAIL stall_hold: got req=%b valid=%b, want req=0 valid=0", imem.imem_req, valid);
            end
            step();
        end
        stall = 1'b0;
        @(negedge clk);
        total++;
        if ({imem.imem_req, valid, instruction, delay, delay2} !== {1'b0, 1'b1, 32'hA5A5_000C, 32'h10, 32'h14}) begin
            bad++;
            $display("FAIL stall_release: got req=%b valid=%b insn=%h delay=%h delay2=%h, want req=0 valid=1 insn=a5a5000c delay=10 delay2=14",
                     imem.imem_req, valid, instruction, delay, delay2);
        end
        $display("stall: pc=%h insn=%h", delay - 32'd4, instruction);
        step();
        ack_en = 1'b0;
        @(negedge clk);
        total++;
        if ({imem.imem_req, imem.imem_addr, valid} !== {1'b1, 32'h10, 1'b0}) begin
            bad++;
            $display("FAIL stall_after: got req=%b addr=%h valid=%b, want req=1 addr=00000010 valid=0",
                     imem.imem_req, imem.imem_addr, valid);
        end
        step();
    endtask

    task automatic test_delay_slot();
        // Redirect while the delay-slot fetch is still waiting.
        do_reset();
        fetch_n(4);
        ack_en = 1'b0; redirect = 1'b1; target = 32'h103;
        @(negedge clk);
        total++;
        if ({imem.imem_addr, valid} !== {32'h10, 1'b0}) begin
            bad++;
            $display("FAIL ds_wait: got addr=%h valid=%b, want addr=00000010 valid=0", imem.imem_addr, valid);
        end
        step();
        redirect = 1'b0; ack_en = 1'b1;
        @(negedge clk);
        total++;
        if ({imem.imem_addr, valid, instruction} !== {32'h10, 1'b1, 32'hA5A5_0010}) begin
            bad++;
            $display("FAIL ds_slot: got addr=%h valid=%b insn=%h, want addr=00000010 valid=1 insn=a5a50010",
                     imem.imem_addr, valid, instruction);
        end
        $display("delay_slot: pc=%h insn=%h", imem.imem_addr, instruction);
        step();
        ack_en = 1'b0;
        @(negedge clk);
        total++;
        if (imem.imem_addr !== 32'h100) begin
            bad++;
            $display("FAIL ds_target: got addr=%h, want addr=00000100", imem.imem_addr);
        end
        step();
        // Redirect in the same cycle as the delay-slot ack.
        do_reset();
        fetch_n(5);
        ack_en = 1'b1; redirect = 1'b1; target = 32'h100;
        @(negedge clk);
        total++;
        if ({valid, instruction, delay} !== {1'b1, 32'hA5A5_0014, 32'h18}) begin
            bad++;
            $display("FAIL ds_same_slot: got valid=%b insn=%h delay=%h, want valid=1 insn=a5a50014 delay=18",
                     valid, instruction, delay);
        end
        $display("delay_slot: pc=%h insn=%h", imem.imem_addr, instruction);
        step();
        redirect = 1'b0; ack_en = 1'b0;
        @(negedge clk);
        total++;
        if (imem.imem_addr !== 32'h100) begin
            bad++;
            $display("FAIL ds_same_target: got addr=%h, want addr=00000100", imem.imem_addr);
        end
        step();
    endtask

    task automatic test_redirect_stall();
        do_reset();
        fetch_n(2);
        ack_en = 1'b1; stall = 1'b1; redirect = 1'b1; target = 32'h300;
        step();
        @(negedge clk);
        total++;
        if (imem.imem_req !== 1'b0) begin
            bad++;
            $display("FAIL rs_hold: got req=%b, want req=0", imem.imem_req);
        end
        step();
        stall = 1'b0; redirect = 1'b0;
        @(negedge clk);
        total++;
        if ({valid, instruction} !== {1'b1, 32'hA5A5_0008}) begin
            bad++;
            $display("FAIL rs_release: got valid=%b insn=%h, want valid=1 insn=a5a50008", valid, instruction);
        end
        step();
        // Two accepted redirects before the delay slot completes: the newer wins.
        ack_en = 1'b0; redirect = 1'b1; target = 32'h100;
        @(negedge clk);
        total++;
        if (imem.imem_addr !== 32'hC) begin
            bad++;
            $display("FAIL rs_ignored: got addr=%h, want addr=0000000c", imem.imem_addr);
        end
        step();
        target = 32'h200;
        step();
        redirect = 1'b0; ack_en = 1'b1;
        @(negedge clk);
        total++;
        if ({valid, instruction} !== {1'b1, 32'hA5A5_000C}) begin
            bad++;
            $display("FAIL rs_slot: got valid=%b insn=%h, want valid=1 insn=a5a5000c", valid, instruction);
        end
        $display("redirect_stall: pc=%h insn=%h", imem.imem_addr, instruction);
        step();
        ack_en = 1'b0;
        @(negedge clk);
        total++;
        if (imem.imem_addr !== 32'h200) begin
            bad++;
            $display("FAIL rs_newest: got addr=%h, want addr=00000200", imem.imem_addr);
        end
        step();
    endtask

    // Random run. The model tracks only the program-order stream: the PC of the next
    // delivered word, and the newest redirect accepted since the previous delivery,
    // which takes effect right after the next delivered word.
    task automatic test_random();
        logic [31:0] m_exp, mp_t, prev_addr;
        logic        mp_v, prev_req, prev_ack, prev_stall;
        int          delivered;
        do_reset();
        m_exp = RESET_PC_DEFAULT; mp_v = 1'b0; mp_t = 32'h0;
        prev_req = 1'b0; prev_ack = 1'b0; prev_stall = 1'b0; prev_addr = 32'h0;
        delivered = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            ack_en   = ($urandom_range(0, 9) < 7);
            stall    = ($urandom_range(0, 3) == 0);
            redirect = ($urandom_range(0, 9) == 0);
            target   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            @(negedge clk);
            if (prev_req && !prev_ack) begin
                total++;
                if ({imem.imem_req, imem.imem_addr} !== {1'b1, prev_addr}) begin
                    bad++;
                    $display("FAIL rnd_addr_stable: got req=%b addr=%h, want req=1 addr=%h", imem.imem_req, imem.imem_addr, prev_addr);
                end
            end
            if (prev_req && prev_ack && prev_stall) begin
                total++;
                if (imem.imem_req !== 1'b0) begin
                    bad++;
                    $display("FAIL rnd_hold_req: got req=%b, want req=0", imem.imem_req);
                end
            end
            if (imem.imem_req === 1'b1) begin
                total++;
                if ((ack_en && !stall) ? (valid !== 1'b1) : ({valid, instruction} !== {1'b0, NOP_INSN})) begin
                    bad++;
                    $display("FAIL rnd_req_valid: got valid=%b insn=%h, want valid=%b", valid, instruction, ack_en && !stall);
                end
            end
            if (redirect && !stall) begin
                mp_v = 1'b1;
                mp_t = target & 32'hFFFF_FFFC;
            end
            if (valid === 1'b1) begin
                total++;
                if ({instruction, delay, delay2} !== {m_exp ^ KEY, m_exp + 32'd4, m_exp + 32'd8}) begin
                    bad++;
                    $display("FAIL rnd_deliver: got insn=%h delay=%h delay2=%h, want insn=%h delay=%h delay2=%h",
                             instruction, delay, delay2, m_exp ^ KEY, m_exp + 32'd4, m_exp + 32'd8);
                end
                $display("random: pc=%h insn=%h", m_exp, instruction);
                delivered++;
                m_exp = mp_v ? mp_t : m_exp + 32'd4;
                mp_v  = 1'b0;
            end
            prev_req = imem.imem_req; prev_ack = ack_en; prev_stall = stall; prev_addr = imem.imem_addr;
            step();
        end
        total++;
        if (delivered < 100) begin
            bad++;
            $display("FAIL rnd_progress: got %0d deliveries, want at least 100", delivered);
        end
        ack_en = 1'b0; stall = 1'b0; redirect = 1'b0;
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall();
        test_delay_slot();
        test_redirect_stall();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction-fetch stage that sits directly upstream of the decode stage. It owns the program counter and issues requests to instruction memory using a req/ack handshake. It hands each fetched instruction to decode together with its PC+4 (`delay`) and PC+8 (`delay2`) values. It honours the decode stall, applies branch/jump redirects with one architectural delay slot, and inserts NOP bubbles while memory is waiting.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `NOP`, default 32'h0000_0000: instruction driven when no fetch is valid.
- `clk` in 1: pipeline clock, rising edge.
- `rstn` in 1: reset; one clock, synchronous, active-low.
- `stall` in 1: decode/hazard stall; same signal that holds the decode register.
- `redirect` in 1: taken branch or jump from decode.
- `target` in 32: redirect destination; bits [1:0] ignored and forced to 0.
- `imem_req` out 1: fetch request valid.
- `imem_addr` out 32: fetch address, word aligned.
- `imem_ack` in 1: `imem_rdata` valid for the current request.
- `imem_rdata` in 32: fetched instruction word.
- `instruction` out 32: to decode `instructionin`.
- `delay` out 32: fetch PC + 4.
- `delay2` out 32: fetch PC + 8.
- `valid` out 1: `instruction` is a real fetch, not a bubble.

## Operation
- State: `pc` (32), `fpc` (PC of buffered word), `buf` (32), `pend_v` and `pend_t` (pending redirect), FSM `{IDLE, REQ, HOLD}`.
- Reset (`rstn`=0 at an edge) sets:
  - state=IDLE, pc=RESET_PC, pend_v=0.
  - Outputs while in reset and IDLE: imem_req=0, valid=0, instruction=NOP, delay=RESET_PC+4, delay2=RESET_PC+8.
- IDLE: unconditionally goes to REQ next cycle.
- REQ:
  - imem_req=1, imem_addr=pc. Address and req stay stable until ack.
  - No ack: valid=0, instruction=NOP. State stays REQ.
  - Ack with stall=0: instruction=imem_rdata, valid=1, delay=pc+4, delay2=pc+8. This is combinational pass-through, because decode registers it.
    - pc ← next_pc. State stays REQ.
  - Ack with stall=1: buf←imem_rdata, fpc←pc, pc←next_pc, state→HOLD.
    - The word is not presented this cycle: valid=0.
- HOLD:
  - imem_req=0. Outputs are instruction=buf, delay=fpc+4, delay2=fpc+8.
  - valid=1 only when stall=0.
  - When stall=0, the buffered word is consumed and state→REQ next cycle. While stall=1, stay in HOLD.
- next_pc:
  - If redirect is accepted this cycle: target.
  - Else if pend_v: pend_t. This clears pend_v.
  - Else: pc+4.
- Redirect acceptance:
  - Sampled only when stall=0. A redirect while stall=1 is ignored, because decode re-asserts it after the stall.
  - The word currently in flight or buffered is the delay slot and is always delivered.
  - If accepted in a cycle with no fetch completion (REQ without ack, or HOLD): pend_v←1, pend_t←target.
  - A newer accepted redirect overwrites pend_t.
- Ack outside REQ is ignored.
- PC arithmetic is modulo 2^32; wrap from 32'hFFFF_FFFC to 0 is silent.

## Timing
- Zero-wait memory (ack in the same cycle as req): one instruction per cycle, no bubbles.
- Fetch-to-decode latency: 0 cycles combinational; decode captures at the next edge.
- N wait cycles produce N NOP bubbles with valid=0.
- Redirect accepted in cycle t:
  - If delay-slot ack is in t: imem_addr=target in t+1.
  - Otherwise: imem_addr=target in the cycle after the delay-slot word completes. If that word went to HOLD, this is the first REQ cycle after the hold.
- After rstn deasserts: IDLE for 1 cycle, then req at RESET_PC.
- Reset mid-request abandons the request. Instruction memory shares rstn and must drop outstanding acks.

## Structure
- Shared pipeline package holds:
  - the `NOP` encoding;
  - the `RESET_PC` default;
  - the FSM state encoding `{IDLE, REQ, HOLD}`, 2 bits.
- Sub-module `pc_next`: combinational next_pc selection (redirect / pending / +4) and alignment masking.
- Adders for +4/+8 reuse the codebase's 32-bit adder.

## Test plan
- Reset: hold rstn=0 for 3 cycles with ack=1 → imem_req=0, valid=0, instruction=NOP. After release: one IDLE cycle, then imem_addr=0x0.
- Zero-wait stream: ack=1, rdata=addr^0xA5A5_0000 → addr 0,4,8,C on consecutive cycles. At addr 8: instruction=0xA5A5_0008, delay=0xC, delay2=0x10.
- Wait states: ack withheld 2 cycles at addr 0x8 → addr held at 0x8, valid=0 and NOP for 2 cycles, then 0xA5A5_0008 with valid=1.
- Stall at ack: stall=1 when 0xC is acked → imem_req=0 and valid=0 while stalled. Drop stall → 0xA5A5_000C presented exactly once with delay=0x10, then addr=0x10.
- Delay slot, redirect before ack: redirect target=0x100 while 0x10 is waiting → 0x10 is still delivered, next addr=0x100. Redirect in the same cycle as ack at 0x14 → next cycle addr=0x100.
- Redirect under stall: redirect=1 with stall=1 → ignored, addr sequence unchanged. Second accepted redirect (0x200) before the delay slot completes → next addr=0x200, not 0x100.
